mcb_port_model: RTL
===================

Name: mcb_port_model

Overview:
- Responder end of the Spartan-6 MCB user-port interface: accepts commands, write data and read requests from a traffic/test initiator, exactly like a real MCB port.
- Backed by an on-chip word memory; used for fast simulation and for on-board loopback of DDR test logic without external DRAM.
- One instance models one bidirectional port: a command FIFO, a write FIFO and a read FIFO.

Parameters:
- ADDR_W, 10, word-address width; memory = 2^ADDR_W x 32 bits.
- CALIB_CYCLES, 16, cycles after reset release before calib_done rises.
- READ_LATENCY, 4, cycles from read-command start to first read-FIFO push.
- REFRESH_CYCLES, 8, busy cycles consumed by a REFRESH command.
- CMD_DEPTH, 4, command FIFO depth.
- DATA_DEPTH, 64, write and read FIFO depth.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- calib_done  out  1  high once the model accepts traffic.
- cmd_en  in  1  push command.
- cmd_instr  in  3  000 WR, 001 RD, 010 WR_AP, 011 RD_AP, 100 REFRESH.
- cmd_bl  in  6  burst length minus 1 (1..64 words).
- cmd_byte_addr  in  30  byte address; bits [1:0] ignored.
- cmd_empty / cmd_full  out  1  command FIFO status.
- wr_en  in  1  push write word.
- wr_mask  in  4  per-byte mask, 1 = byte not written.
- wr_data  in  32  write word.
- wr_full / wr_empty  out  1  write FIFO status.
- wr_count  out  7  write FIFO occupancy, 0..64.
- wr_underrun  out  1  level: executing write stalled on an empty write FIFO.
- wr_error  out  1  sticky error flag.
- rd_en  in  1  pop read word.
- rd_data  out  32  head of read FIFO (first-word fall-through).
- rd_full / rd_empty  out  1  read FIFO status.
- rd_count  out  7  read FIFO occupancy, 0..64.
- rd_overflow  out  1  one-cycle pulse when a push is dropped.
- rd_error  out  1  sticky error flag.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - All FIFOs emptied; empty flags = 1; full flags, counts, errors, underrun, overflow and calib_done = 0.
  - rd_data = 0; FSM = CALIB; calib counter = 0.
  - Memory contents are not reset.
- Reset asserted mid-operation aborts any command at once; queued data is discarded.
- Calibration:
  - calib_done rises exactly CALIB_CYCLES clocks after rst_n deasserts, then stays high.
  - cmd_en and wr_en before calib_done are still accepted into the FIFOs; execution waits for calib_done.
- FIFO push and pop rules:
  - Push while full is dropped. Dropped cmd: no flag. Dropped write: sets wr_error.
  - rd_en while empty: rd_data holds, rd_error is set.
  - Simultaneous push and pop on a FIFO is legal when it is full or empty, provided the pop itself is valid; count is unchanged.
  - Counts update on the cycle after push or pop.
- FSM states: CALIB, IDLE, WRITE, READ_WAIT, READ, REFRESH.
  - IDLE: if cmd FIFO is non-empty, pop and latch instr, bl and word address = byte_addr[ADDR_W+1:2]. Go to WRITE (WR/WR_AP), READ_WAIT (RD/RD_AP) or REFRESH. Undefined opcodes: 1-cycle no-op, back to IDLE.
  - WRITE, each cycle with wr FIFO non-empty: pop one word, merge unmasked bytes into mem[addr], addr++, remaining--. Exit to IDLE after bl+1 words.
  - WRITE with wr FIFO empty: stall, wr_underrun = 1, wr_error set.
  - READ_WAIT: count READ_LATENCY-1 cycles, then go to READ.
  - READ: push mem[addr] into rd FIFO every cycle, addr++. Exit to IDLE after bl+1 pushes. Push while full: word dropped, rd_overflow pulses, rd_error set; the burst still advances.
  - REFRESH: busy REFRESH_CYCLES cycles, no memory access.
- Auto-precharge variants behave identically to plain WR/RD.
- Address arithmetic: word address increments modulo 2^ADDR_W (wraps 2^ADDR_W-1 -> 0); high byte_addr bits beyond ADDR_W+2 are ignored.
- Memory read is synchronous, 1-cycle; the READ pipeline accounts for it so push spacing is one word per cycle.
- A write followed by a read of the same address observes the new data, since commands execute strictly in order.
- wr_error and rd_error clear only on reset.

Decomposition:
- Shared package mcb_pkg:
  - instruction codes (WR, RD, WR_AP, RD_AP, REFRESH);
  - FSM state enumeration;
  - data width 32 and mask width 4.
- Sub-module sync_fifo:
  - parameters WIDTH and DEPTH; first-word fall-through; outputs full, empty and count.
  - Instantiated three times: cmd FIFO (width 3+6+30), wr FIFO (width 36), rd FIFO (width 32).

Test Plan:
- Reset/calib: hold rst_n low 5 cycles, then release -> calib_done = 0 for 16 cycles then 1; cmd_empty = wr_empty = rd_empty = 1; wr_count = rd_count = 0.
- Burst loopback: push 64 distinct words, WR bl=63 at 0x0, then RD bl=63 at 0x0 -> rd_count reaches 64; popped data match in order; wr_error = rd_error = 0.
- Byte mask: write 0xFFFFFFFF at 0x40, then write 0x12345678 mask 4'b0101 at 0x40, read bl=0 -> rd_data = 0x12FF56FF.
- Underrun: WR bl=3 at 0x0 with an empty wr FIFO -> wr_underrun = 1, wr_error = 1; push 4 words -> command completes, wr_underrun = 0, readback matches.
- Overflow: two RD bl=63 commands, rd_en held low -> rd_full = 1, rd_count = 64, rd_overflow pulses 64 times, rd_error = 1.
- Wrap and reset: WR bl=3 at byte 0xFF8 (ADDR_W=10) -> words written at indices 1022, 1023, 0, 1. Assert rst_n low mid-burst -> all flags and counts return to reset values within the same cycle.

Source files
------------

// File: rtl/mcb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mcb_pkg
//  Purpose  : Shared definitions for the MCB user-port responder model:
//             instruction opcodes, FSM state encoding, data/mask widths and
//             the packed command-word field widths.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mcb_pkg;

  localparam int DATA_W  = 32;
  localparam int MASK_W  = 4;
  localparam int INSTR_W = 3;
  localparam int BL_W    = 6;
  localparam int BADDR_W = 30;
  localparam int CMD_W   = INSTR_W + BL_W + BADDR_W;

  localparam logic [INSTR_W-1:0] INSTR_WR      = 3'b000;
  localparam logic [INSTR_W-1:0] INSTR_RD      = 3'b001;
  localparam logic [INSTR_W-1:0] INSTR_WR_AP   = 3'b010;
  localparam logic [INSTR_W-1:0] INSTR_RD_AP   = 3'b011;
  localparam logic [INSTR_W-1:0] INSTR_REFRESH = 3'b100;

  typedef enum logic [2:0] {
    ST_CALIB     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_READ      = 3'd4,
    ST_REFRESH   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock first-word-fall-through FIFO. dout_o always shows
//             the head entry. A push while full is dropped unless a valid pop
//             happens in the same cycle; a pop while empty is ignored.
//  Ports    : clk, rst_n        clock / async active-low reset
//             push_i, din_i     write side
//             pop_i, dout_o     read side (FWFT head)
//             full_o, empty_o   status flags
//             count_o           registered occupancy 0..DEPTH
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;
  logic             do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A valid pop frees a slot in the same cycle, so a full FIFO may accept
  // a push alongside it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage is cleared on reset so the FWFT head reads zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mcb_port_model.sv
`default_nettype none
// ============================================================================
//  Module   : mcb_port_model
//  Purpose  : Responder side of a Spartan-6 MCB bidirectional user port,
//             backed by a 2^ADDR_W x 32 on-chip word memory. Commands, write
//             words and read words pass through FIFOs exactly like the real
//             port; a small FSM executes commands strictly in order.
//  Ports    : clk, rst_n                       clock / async active-low reset
//             calib_done_o                      traffic accepted from now on
//             cmd_en_i/instr/bl/byte_addr       command push
//             cmd_empty_o, cmd_full_o           command FIFO status
//             wr_en_i, wr_mask_i, wr_data_i     write-data push
//             wr_full/empty/count_o             write FIFO status
//             wr_underrun_o, wr_error_o         write stall level / sticky error
//             rd_en_i, rd_data_o                read-data pop (FWFT)
//             rd_full/empty/count_o             read FIFO status
//             rd_overflow_o, rd_error_o         dropped-push pulse / sticky error
//  Revision : 1.0  initial release
// ============================================================================
module mcb_port_model
  import mcb_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int CALIB_CYCLES   = 16,
  parameter int READ_LATENCY   = 4,   // must be >= 2
  parameter int REFRESH_CYCLES = 8,
  parameter int CMD_DEPTH      = 4,
  parameter int DATA_DEPTH     = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic                              calib_done_o,
  input  logic                              cmd_en_i,
  input  logic [INSTR_W-1:0]                cmd_instr_i,
  input  logic [BL_W-1:0]                   cmd_bl_i,
  input  logic [BADDR_W-1:0]                cmd_byte_addr_i,
  output logic                              cmd_empty_o,
  output logic                              cmd_full_o,
  input  logic                              wr_en_i,
  input  logic [MASK_W-1:0]                 wr_mask_i,
  input  logic [DATA_W-1:0]                 wr_data_i,
  output logic                              wr_full_o,
  output logic                              wr_empty_o,
  output logic [$clog2(DATA_DEPTH+1)-1:0]   wr_count_o,
  output logic                              wr_underrun_o,
  output logic                              wr_error_o,
  input  logic                              rd_en_i,
  output logic [DATA_W-1:0]                 rd_data_o,
  output logic                              rd_full_o,
  output logic                              rd_empty_o,
  output logic [$clog2(DATA_DEPTH+1)-1:0]   rd_count_o,
  output logic                              rd_overflow_o,
  output logic                              rd_error_o
);

  localparam int CAL_W    = $clog2(CALIB_CYCLES + 1);
  localparam int WAIT_MAX = (READ_LATENCY > REFRESH_CYCLES) ? READ_LATENCY : REFRESH_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  // ---------------------------------------------------------------- FIFOs
  logic [CMD_W-1:0]               cmd_dout;
  logic                           cmd_pop;
  logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count_unused;
  logic [MASK_W+DATA_W-1:0]       wr_dout;
  logic                           wr_pop;
  logic [DATA_W-1:0]              rdata_q;
  logic                           rvalid_q;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_en_i),
    .din_i   ({cmd_instr_i, cmd_bl_i, cmd_byte_addr_i}),
    .pop_i   (cmd_pop),
    .dout_o  (cmd_dout),
    .full_o  (cmd_full_o),
    .empty_o (cmd_empty_o),
    .count_o (cmd_count_unused)
  );

  sync_fifo #(.WIDTH(MASK_W + DATA_W), .DEPTH(DATA_DEPTH)) u_wr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_en_i),
    .din_i   ({wr_mask_i, wr_data_i}),
    .pop_i   (wr_pop),
    .dout_o  (wr_dout),
    .full_o  (wr_full_o),
    .empty_o (wr_empty_o),
    .count_o (wr_count_o)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH)) u_rd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rvalid_q),
    .din_i   (rdata_q),
    .pop_i   (rd_en_i),
    .dout_o  (rd_data_o),
    .full_o  (rd_full_o),
    .empty_o (rd_empty_o),
    .count_o (rd_count_o)
  );

  // Command word fields. Only byte-address bits [ADDR_W+1:2] select a word.
  logic [INSTR_W-1:0] cmd_instr;
  logic [BL_W-1:0]    cmd_bl;
  logic [BADDR_W-1:0] cmd_baddr;
  logic [ADDR_W-1:0]  cmd_waddr;
  logic               cmd_addr_unused;

  assign cmd_instr       = cmd_dout[CMD_W-1 -: INSTR_W];
  assign cmd_bl          = cmd_dout[BADDR_W +: BL_W];
  assign cmd_baddr       = cmd_dout[BADDR_W-1:0];
  assign cmd_waddr       = cmd_baddr[ADDR_W+1:2];
  assign cmd_addr_unused = ^{cmd_baddr[BADDR_W-1:ADDR_W+2], cmd_baddr[1:0]};

  // ---------------------------------------------------------- calibration
  logic [CAL_W-1:0] calib_cnt_q;
  logic             calib_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_cnt_q  <= '0;
      calib_done_q <= 1'b0;
    end else if (!calib_done_q) begin
      if (calib_cnt_q == CAL_W'(CALIB_CYCLES - 1)) begin
        calib_done_q <= 1'b1;
      end else begin
        calib_cnt_q <= calib_cnt_q + CAL_W'(1);
      end
    end
  end

  assign calib_done_o = calib_done_q;

  // ------------------------------------------------------------------ FSM
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BL_W-1:0]   bl_q, bl_d;
  logic [BL_W-1:0]   beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_we;
  logic              mem_re;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CALIB;
      addr_q  <= '0;
      bl_q    <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bl_q    <= bl_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bl_d    = bl_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    cmd_pop = 1'b0;
    wr_pop  = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      ST_CALIB: begin
        if (calib_done_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!cmd_empty_o) begin
          cmd_pop = 1'b1;
          addr_d  = cmd_waddr;
          bl_d    = cmd_bl;
          beat_d  = '0;
          wait_d  = '0;
          case (cmd_instr)
            INSTR_WR, INSTR_WR_AP: state_d = ST_WRITE;
            INSTR_RD, INSTR_RD_AP: state_d = ST_READ_WAIT;
            INSTR_REFRESH:         state_d = ST_REFRESH;
            default:               state_d = ST_IDLE;  // undefined: one-cycle no-op
          endcase
        end
      end
      ST_WRITE: begin
        if (!wr_empty_o) begin
          wr_pop = 1'b1;
          mem_we = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          if (beat_q == bl_q) state_d = ST_IDLE;
          else                beat_d  = beat_q + BL_W'(1);
        end
      end
      ST_READ_WAIT: begin
        // READ_LATENCY-1 wait cycles plus the synchronous memory read stage.
        if (wait_q == WAIT_W'(READ_LATENCY - 2)) state_d = ST_READ;
        else                                     wait_d  = wait_q + WAIT_W'(1);
      end
      ST_READ: begin
        mem_re = 1'b1;
        addr_d = addr_q + ADDR_W'(1);
        if (beat_q == bl_q) state_d = ST_IDLE;
        else                beat_d  = beat_q + BL_W'(1);
      end
      ST_REFRESH: begin
        if (wait_q == WAIT_W'(REFRESH_CYCLES - 1)) state_d = ST_IDLE;
        else                                       wait_d  = wait_q + WAIT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------- memory
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [MASK_W-1:0] wmask;
  logic [DATA_W-1:0] wdata;

  assign wmask = wr_dout[MASK_W+DATA_W-1 -: MASK_W];
  assign wdata = wr_dout[DATA_W-1:0];

  // Contents deliberately not reset; only the read-valid flag is.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wmask[b]) mem_q[addr_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (mem_re) rdata_q <= mem_q[addr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid_q <= 1'b0;
    else        rvalid_q <= mem_re;
  end

  // ------------------------------------------------------- status / errors
  logic wr_drop;
  logic rd_drop;
  logic rd_underflow;
  logic wr_error_q;
  logic rd_error_q;

  // A read pop is always valid when the FIFO is full, so it makes room.
  assign wr_drop       = wr_en_i && wr_full_o && !wr_pop;
  assign rd_drop       = rvalid_q && rd_full_o && !rd_en_i;
  assign rd_underflow  = rd_en_i && rd_empty_o;
  assign wr_underrun_o = (state_q == ST_WRITE) && wr_empty_o;
  assign rd_overflow_o = rd_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_error_q <= 1'b0;
      rd_error_q <= 1'b0;
    end else begin
      if (wr_drop || wr_underrun_o) wr_error_q <= 1'b1;
      if (rd_drop || rd_underflow)  rd_error_q <= 1'b1;
    end
  end

  assign wr_error_o = wr_error_q;
  assign rd_error_o = rd_error_q;

endmodule
`default_nettype wire
